// File: rtl/id_ex_stage_reg_pkg.sv
// Shared types and defaults for the ID->EX pipeline boundary.
// Bus width tracks the core's IdToExBusWidth.
package id_ex_stage_reg_pkg;

    localparam int ID_TO_EX_BUS_W = 200;
    localparam int STALL_CNT_W    = 32;
    localparam int MAX_STALL_DEF  = 4;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID->EX handshake and bus bundle.
// The slave side is the stage register; the master side is the ID/EX/MEM surroundings.
interface id_ex_stage_reg_if #(
    parameter int BUS_W = id_ex_stage_reg_pkg::ID_TO_EX_BUS_W
);
    logic             id_valid;
    logic [BUS_W-1:0] id_to_ex_bus;
    logic             regs_read_ready;
    logic             ex_ready_go;
    logic             mem_allowin;
    logic             id_allowin;
    logic             ex_valid;
    logic [BUS_W-1:0] ex_bus;

    modport slave (
        input  id_valid, id_to_ex_bus, regs_read_ready, ex_ready_go, mem_allowin,
        output id_allowin, ex_valid, ex_bus
    );

    modport master (
        output id_valid, id_to_ex_bus, regs_read_ready, ex_ready_go, mem_allowin,
        input  id_allowin, ex_valid, ex_bus
    );
endinterface

// File: rtl/id_ex_stage_reg_hazard_stall_monitor.sv
// Hazard-stall statistics: RUN/STALL FSM, consecutive-stall run length,
// saturating total-stall counter and sticky timeout flag.
module id_ex_stage_reg_hazard_stall_monitor
    import id_ex_stage_reg_pkg::*;
#(
    parameter int CNT_W     = STALL_CNT_W,
    parameter int MAX_STALL = MAX_STALL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic             regs_read_ready_i,
    input  logic             excp_flush_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             hazard_timeout_o
);
    localparam int RUN_W = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_TO  = RUN_W'(MAX_STALL);

    hz_state_e        state_q;
    logic [RUN_W-1:0] run_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic             hz;

    // A flush is not a hazard: it cancels the stalled instruction outright.
    assign hz = id_valid_i && !regs_read_ready_i && !excp_flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HZ_RUN;
            run_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (excp_flush_i) begin
                state_q <= HZ_RUN;
                run_q   <= '0;
            end else begin
                case (state_q)
                    HZ_RUN: begin
                        if (hz) begin
                            state_q <= HZ_STALL;
                            run_q   <= RUN_W'(1);
                        end else begin
                            run_q   <= '0;
                        end
                    end
                    HZ_STALL: begin
                        if (hz) begin
                            if (run_q != RUN_SAT) run_q <= run_q + RUN_W'(1);
                        end else begin
                            state_q <= HZ_RUN;
                            run_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= HZ_RUN;
                        run_q   <= '0;
                    end
                endcase
            end
            if (hz && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
            if (hz && (run_q == RUN_TO)) timeout_q <= 1'b1;
        end
    end

    assign stall_cnt_o      = cnt_q;
    assign hazard_timeout_o = timeout_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline boundary: EX input register with ID handshake, bubble
// insertion on operand hazards and flush on exception/ertn.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int BUS_W     = ID_TO_EX_BUS_W,
    parameter int CNT_W     = STALL_CNT_W,
    parameter int MAX_STALL = MAX_STALL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_stage_reg_if.slave io,
    input  logic             excp_flush_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             hazard_timeout_o
);
    logic             id_ready_go;
    logic             ex_allowin;
    logic             id_to_ex_valid;
    logic             ex_valid_q, ex_valid_d;
    logic [BUS_W-1:0] ex_bus_q, ex_bus_d;

    assign id_ready_go    = io.regs_read_ready;
    assign ex_allowin     = !ex_valid_q || (io.ex_ready_go && io.mem_allowin);
    assign id_to_ex_valid = io.id_valid && id_ready_go && !excp_flush_i;
    // Flush empties ID, so IF must be allowed to refill it immediately.
    assign io.id_allowin  = excp_flush_i || !io.id_valid || (id_ready_go && ex_allowin);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_bus_d   = ex_bus_q;
        if (excp_flush_i) begin
            ex_valid_d = 1'b0;
        end else if (ex_allowin) begin
            ex_valid_d = id_to_ex_valid;
            if (id_to_ex_valid) ex_bus_d = io.id_to_ex_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_bus_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_bus_q   <= ex_bus_d;
        end
    end

    assign io.ex_valid = ex_valid_q;
    assign io.ex_bus   = ex_bus_q;

    id_ex_stage_reg_hazard_stall_monitor #(
        .CNT_W     (CNT_W),
        .MAX_STALL (MAX_STALL)
    ) u_hz_mon (
        .clk               (clk),
        .rst               (rst),
        .id_valid_i        (io.id_valid),
        .regs_read_ready_i (io.regs_read_ready),
        .excp_flush_i      (excp_flush_i),
        .stall_cnt_o       (stall_cnt_o),
        .hazard_timeout_o  (hazard_timeout_o)
    );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for the ID->EX stage register: handshake, bubbles,
// backpressure, flush and hazard-stall statistics.
module tb_id_ex_stage_reg;
    localparam int BUS_W     = 200;
    localparam int CNT_W     = 32;
    localparam int MAX_STALL = 4;

    logic             clk;
    logic             rst;
    logic             excp_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic             hazard_timeout;

    int n_chk;
    int n_fail;

    id_ex_stage_reg_if #(.BUS_W(BUS_W)) bus_if ();

    id_ex_stage_reg #(
        .BUS_W     (BUS_W),
        .CNT_W     (CNT_W),
        .MAX_STALL (MAX_STALL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .io               (bus_if.slave),
        .excp_flush_i     (excp_flush),
        .stall_cnt_o      (stall_cnt),
        .hazard_timeout_o (hazard_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BUS_W-1:0] pat(input logic [7:0] b);
        return {(BUS_W/8){b}};
    endfunction

    task automatic drive(input logic v, input logic rdy, input logic rg, input logic ma,
                         input logic fl, input logic [BUS_W-1:0] b);
        bus_if.id_valid        = v;
        bus_if.regs_read_ready = rdy;
        bus_if.ex_ready_go     = rg;
        bus_if.mem_allowin     = ma;
        excp_flush             = fl;
        bus_if.id_to_ex_bus    = b;
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // Reset with random inputs
        rst = 1'b1;
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              {7{$urandom}});
        tick();
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              {7{$urandom}});
        tick();
        chk("rst_ex_valid", 256'(bus_if.ex_valid), 256'(0));
        chk("rst_ex_bus", 256'(bus_if.ex_bus), 256'(0));
        chk("rst_stall_cnt", 256'(stall_cnt), 256'(0));
        chk("rst_timeout", 256'(hazard_timeout), 256'(0));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_id_allowin_idle", 256'(bus_if.id_allowin), 256'(1));
        rst = 1'b0;

        // Free flow
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pat(8'hA5));
        chk("flow_id_allowin", 256'(bus_if.id_allowin), 256'(1));
        tick();
        chk("flow_ex_valid", 256'(bus_if.ex_valid), 256'(1));
        chk("flow_ex_bus_a5", 256'(bus_if.ex_bus), 256'(pat(8'hA5)));
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pat(8'h5A));
        tick();
        chk("flow_ex_bus_5a", 256'(bus_if.ex_bus), 256'(pat(8'h5A)));

        // Load-use: one hazard cycle
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pat(8'h33));
        chk("lu_id_allowin", 256'(bus_if.id_allowin), 256'(0));
        tick();
        chk("lu_bubble_valid", 256'(bus_if.ex_valid), 256'(0));
        chk("lu_bubble_bus_held", 256'(bus_if.ex_bus), 256'(pat(8'h5A)));
        chk("lu_stall_cnt", 256'(stall_cnt), 256'(1));
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pat(8'h33));
        tick();
        chk("lu_resume_valid", 256'(bus_if.ex_valid), 256'(1));
        chk("lu_resume_bus", 256'(bus_if.ex_bus), 256'(pat(8'h33)));
        chk("lu_resume_cnt", 256'(stall_cnt), 256'(1));

        // EX backpressure for 3 cycles
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, pat(8'h44));
        for (int i = 0; i < 3; i++) begin
            chk("bp_id_allowin", 256'(bus_if.id_allowin), 256'(0));
            tick();
            chk("bp_ex_valid", 256'(bus_if.ex_valid), 256'(1));
            chk("bp_ex_bus", 256'(bus_if.ex_bus), 256'(pat(8'h33)));
            chk("bp_stall_cnt", 256'(stall_cnt), 256'(1));
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pat(8'h44));
        tick();
        chk("bp_release_bus", 256'(bus_if.ex_bus), 256'(pat(8'h44)));

        // Flush during a stall
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pat(8'h55));
        tick();
        chk("fl_stall_cnt_pre", 256'(stall_cnt), 256'(2));
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, pat(8'h55));
        chk("fl_id_allowin", 256'(bus_if.id_allowin), 256'(1));
        tick();
        chk("fl_ex_valid", 256'(bus_if.ex_valid), 256'(0));
        chk("fl_stall_cnt_held", 256'(stall_cnt), 256'(2));
        chk("fl_bus_held", 256'(bus_if.ex_bus), 256'(pat(8'h44)));

        // Flush coinciding with a handshake while EX is backpressured
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pat(8'h66));
        tick();
        chk("flhs_load", 256'(bus_if.ex_bus), 256'(pat(8'h66)));
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, pat(8'h77));
        tick();
        chk("flhs_valid_killed", 256'(bus_if.ex_valid), 256'(0));
        chk("flhs_bus_held", 256'(bus_if.ex_bus), 256'(pat(8'h66)));

        // Long stall trips the timeout on the 5th cycle
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pat(8'h88));
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("to_timeout", 256'(hazard_timeout), 256'(i == 5));
        end
        chk("to_stall_cnt", 256'(stall_cnt), 256'(5));
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pat(8'h88));
        tick();
        tick();
        chk("to_sticky", 256'(hazard_timeout), 256'(1));
        chk("to_cnt_stable", 256'(stall_cnt), 256'(5));

        // Reset mid-stall clears everything
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pat(8'h99));
        tick();
        rst = 1'b1;
        tick();
        chk("rms_ex_valid", 256'(bus_if.ex_valid), 256'(0));
        chk("rms_ex_bus", 256'(bus_if.ex_bus), 256'(0));
        chk("rms_stall_cnt", 256'(stall_cnt), 256'(0));
        chk("rms_timeout", 256'(hazard_timeout), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
